// File: rtl/mem_line_responder_if.sv
// ---------------------------------------------------------------------------
// mem_line_responder_if
//   Memory-side bus between a line-granular cache controller (master) and
//   the backing-memory responder (slave).
//
//   Signals
//     mem_read, mem_write : request levels from the controller
//     mem_addr            : byte address, bits [31:6] select the line
//     mem_write_data      : write-back word for the current beat
//     mem_read_data       : refill word for the current beat
//     mem_rvalid          : mem_read_data holds beat mem_beat of a refill
//     mem_wack            : mem_write_data is captured at the end of the cycle
//     mem_beat            : current beat index 0..15
//     mem_busy            : responder is not idle
//     mem_done            : one-cycle transaction-complete pulse
//     mem_conflict        : one-cycle pulse, read and write requested together
//
//   Handshake: a request is a level that the responder samples only while
//   idle (mem_busy low). Once accepted, the burst runs without stalls: every
//   cycle with mem_rvalid high carries one refill word, every cycle with
//   mem_wack high consumes one write word, and the master must drop its
//   request when mem_done pulses or a new transaction is started.
// ---------------------------------------------------------------------------
interface mem_line_responder_if #(
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_rvalid;
  logic              mem_wack;
  logic [3:0]        mem_beat;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_conflict;

  modport master (
    output mem_read, mem_write, mem_addr, mem_write_data,
    input  mem_read_data, mem_rvalid, mem_wack, mem_beat,
           mem_busy, mem_done, mem_conflict
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_write_data,
    output mem_read_data, mem_rvalid, mem_wack, mem_beat,
           mem_busy, mem_done, mem_conflict
  );
endinterface

// File: rtl/mem_line_responder.sv
// ---------------------------------------------------------------------------
// mem_line_responder
//   Backing-memory model for a line-based cache. Accepts a line refill or
//   write-back request while idle, waits LATENCY cycles, then moves one
//   64-byte line as 16 back-to-back beats, then pulses mem_done.
//
//   Ports
//     clk       : clock, rising edge
//     rst_b     : asynchronous active-low reset
//     mem       : slave side of mem_line_responder_if
//     dbg_state : current FSM state (IDLE=0, WAIT=1, RBURST=2, WBURST=3,
//                 DONE=4)
//
//   All outputs come straight from flops; nothing combinational reaches an
//   output from an input.
// ---------------------------------------------------------------------------
module mem_line_responder #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 4,
  parameter logic [DATA_W-1:0] INIT_WORD   = DATA_W'(32'hDEADBEEF)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  mem_line_responder_if.slave  mem,
  output logic [2:0]           dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RBURST = 3'd2,
    S_WBURST = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q,    state_d;
  logic                    op_write_q, op_write_d;
  logic [25:0]             line_q,     line_d;
  logic [7:0]              cnt_q,      cnt_d;
  logic [3:0]              beat_q,     beat_d;
  logic [DATA_W-1:0]       rdata_q,    rdata_d;
  logic                    rvalid_q,   rvalid_d;
  logic                    wack_q,     wack_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;
  logic                    conflict_q, conflict_d;
  logic [DEPTH_WORDS-1:0]  written_q,  written_d;

  // Word storage is deliberately not reset; the written bits decide whether
  // a word returns its stored value or INIT_WORD.
  logic [DATA_W-1:0]       storage [DEPTH_WORDS];

  logic [AW-1:0]           idx_cur;
  logic [AW-1:0]           idx_nxt;

  // Line and beat concatenate into a word index; upper bits drop off so
  // out-of-range lines alias onto the array.
  assign idx_cur = AW'({line_q, beat_q});

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    written_d  = written_q;
    conflict_d = 1'b0;
    rdata_d    = rdata_q;
    idx_nxt    = '0;

    case (state_q)
      S_IDLE: begin
        // Write wins when both are requested; the read is simply dropped.
        if (mem.mem_write || mem.mem_read) begin
          state_d    = S_WAIT;
          op_write_d = mem.mem_write;
          line_d     = mem.mem_addr[31:6];
          cnt_d      = 8'(LATENCY - 1);
          conflict_d = mem.mem_write && mem.mem_read;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = op_write_q ? S_WBURST : S_RBURST;
          beat_d  = 4'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RBURST: begin
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'd15) state_d = S_DONE;
      end
      S_WBURST: begin
        beat_d             = beat_q + 4'd1;
        written_d[idx_cur] = 1'b1;
        if (beat_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered versions of what the next state implies, so
    // they line up with the state they describe.
    busy_d   = (state_d != S_IDLE);
    rvalid_d = (state_d == S_RBURST);
    wack_d   = (state_d == S_WBURST);
    done_d   = (state_d == S_DONE);

    // The read register is loaded on the edge that enters each read beat.
    if (state_d == S_RBURST) begin
      idx_nxt = AW'({line_q, beat_d});
      rdata_d = written_q[idx_nxt] ? storage[idx_nxt] : INIT_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      op_write_q <= 1'b0;
      line_q     <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      wack_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      written_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      wack_q     <= wack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
      written_q  <= written_d;
    end
  end

  // Reset forces state_q to IDLE asynchronously, so an interrupted write
  // burst stops storing immediately.
  always_ff @(posedge clk) begin
    if (state_q == S_WBURST) storage[idx_cur] <= mem.mem_write_data;
  end

  assign mem.mem_read_data = rdata_q;
  assign mem.mem_rvalid    = rvalid_q;
  assign mem.mem_wack      = wack_q;
  assign mem.mem_beat      = beat_q;
  assign mem.mem_busy      = busy_q;
  assign mem.mem_done      = done_q;
  assign mem.mem_conflict  = conflict_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_line_responder_if #(.DATA_W(32)) if0 ();
  mem_line_responder_if #(.DATA_W(32)) if1 ();
  logic [2:0] dbg0, dbg1;

  mem_line_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(4)) u0 (
    .clk(clk), .rst_b(rst_b), .mem(if0), .dbg_state(dbg0)
  );
  mem_line_responder #(.DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) u1 (
    .clk(clk), .rst_b(rst_b), .mem(if1), .dbg_state(dbg1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle observation of u0, index = cycle number after accept edge.
  logic [31:0] o_rdata  [64];
  logic        o_rvalid [64];
  logic        o_wack   [64];
  logic [3:0]  o_beat   [64];
  logic        o_busy   [64];
  logic        o_done   [64];
  logic        o_conf   [64];

  // ---------------- driver ----------------
  // Call right after a negedge with u0 idle. Request is accepted at the next
  // posedge (E0); cycles 1..ncyc are then recorded at each negedge. Write
  // words wbase+k are presented while mem_beat=k.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wbase, input bit hold_rd, input int ncyc);
    if0.mem_read  = rd;
    if0.mem_write = wr;
    if0.mem_addr  = addr;
    @(posedge clk);
    #1;
    if0.mem_write = 1'b0;
    if (!hold_rd) if0.mem_read = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      o_rdata[c]  = if0.mem_read_data;
      o_rvalid[c] = if0.mem_rvalid;
      o_wack[c]   = if0.mem_wack;
      o_beat[c]   = if0.mem_beat;
      o_busy[c]   = if0.mem_busy;
      o_done[c]   = if0.mem_done;
      o_conf[c]   = if0.mem_conflict;
      if (if0.mem_wack) if0.mem_write_data = wbase + 32'(if0.mem_beat);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if0.mem_read = 0; if0.mem_write = 0; if0.mem_addr = 0; if0.mem_write_data = 0;
    if1.mem_read = 0; if1.mem_write = 0; if1.mem_addr = 0; if1.mem_write_data = 0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (if0.mem_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", if0.mem_read_data); end
    n_cmp++; if (if0.mem_rvalid !== 1'b0)     begin n_fail++; $display("FAIL reset_rvalid: got %b exp 0", if0.mem_rvalid); end
    n_cmp++; if (if0.mem_wack !== 1'b0)       begin n_fail++; $display("FAIL reset_wack: got %b exp 0", if0.mem_wack); end
    n_cmp++; if (if0.mem_beat !== 4'h0)       begin n_fail++; $display("FAIL reset_beat: got %h exp 0", if0.mem_beat); end
    n_cmp++; if (if0.mem_busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b exp 0", if0.mem_busy); end
    n_cmp++; if (if0.mem_done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b exp 0", if0.mem_done); end
    n_cmp++; if (if0.mem_conflict !== 1'b0)   begin n_fail++; $display("FAIL reset_conflict: got %b exp 0", if0.mem_conflict); end
    n_cmp++; if (dbg0 !== 3'd0)               begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg0); end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_init();
    int dcnt;
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 22);
    n_cmp++; if (o_busy[1] !== 1'b1) begin n_fail++; $display("FAIL rinit_busy_rise: got %b exp 1", o_busy[1]); end
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (o_rvalid[c] !== 1'b0) begin n_fail++; $display("FAIL rinit_wait_rvalid c%0d: got %b exp 0", c, o_rvalid[c]); end
    end
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (o_rvalid[5+k] !== 1'b1) begin n_fail++; $display("FAIL rinit_rvalid k%0d: got %b exp 1", k, o_rvalid[5+k]); end
      n_cmp++; if (o_beat[5+k] !== 4'(k))  begin n_fail++; $display("FAIL rinit_beat k%0d: got %0d exp %0d", k, o_beat[5+k], k); end
      n_cmp++; if (o_rdata[5+k] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rinit_data k%0d: got %h exp deadbeef", k, o_rdata[5+k]); end
    end
    dcnt = 0;
    for (int c = 1; c <= 22; c++) if (o_done[c] === 1'b1) dcnt++;
    n_cmp++; if (o_done[21] !== 1'b1) begin n_fail++; $display("FAIL rinit_done_c21: got %b exp 1", o_done[21]); end
    n_cmp++; if (dcnt != 1)           begin n_fail++; $display("FAIL rinit_done_count: got %0d exp 1", dcnt); end
    n_cmp++; if (o_busy[21] !== 1'b1) begin n_fail++; $display("FAIL rinit_busy_c21: got %b exp 1", o_busy[21]); end
    n_cmp++; if (o_busy[22] !== 1'b0) begin n_fail++; $display("FAIL rinit_idle_c22: got %b exp 0", o_busy[22]); end
  endtask

  task automatic test_write_read();
    int wcnt, dcnt;
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h100, 1'b0, 22);
    wcnt = 0; dcnt = 0;
    for (int c = 1; c <= 22; c++) begin
      if (o_wack[c] === 1'b1) wcnt++;
      if (o_done[c] === 1'b1) dcnt++;
    end
    n_cmp++; if (wcnt != 16) begin n_fail++; $display("FAIL wr_wack_count: got %0d exp 16", wcnt); end
    n_cmp++; if (o_wack[5] !== 1'b1 || o_wack[20] !== 1'b1) begin n_fail++; $display("FAIL wr_wack_window: got %b%b exp 11", o_wack[5], o_wack[20]); end
    n_cmp++; if (dcnt != 1 || o_done[21] !== 1'b1) begin n_fail++; $display("FAIL wr_done: got count %0d c21 %b exp 1 1", dcnt, o_done[21]); end
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 22);
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (o_rdata[5+k] !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL wr_readback k%0d: got %h exp %h", k, o_rdata[5+k], 32'h100 + 32'(k)); end
    end
    dcnt = 0;
    for (int c = 1; c <= 22; c++) if (o_done[c] === 1'b1) dcnt++;
    n_cmp++; if (dcnt != 1) begin n_fail++; $display("FAIL wr_rd_done_count: got %0d exp 1", dcnt); end
  endtask

  task automatic test_wrap();
    run_txn(1'b0, 1'b1, 32'h0000_1040, 32'hA0, 1'b0, 22);
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 22);
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (o_rdata[5+k] !== 32'hA0 + 32'(k)) begin n_fail++; $display("FAIL wrap_data k%0d: got %h exp %h", k, o_rdata[5+k], 32'hA0 + 32'(k)); end
    end
  endtask

  task automatic test_conflict();
    int ccnt, wcnt, rcnt;
    run_txn(1'b1, 1'b1, 32'h0000_0080, 32'h200, 1'b1, 22);
    ccnt = 0; wcnt = 0; rcnt = 0;
    for (int c = 1; c <= 22; c++) begin
      if (o_conf[c] === 1'b1)   ccnt++;
      if (o_wack[c] === 1'b1)   wcnt++;
      if (o_rvalid[c] === 1'b1) rcnt++;
    end
    n_cmp++; if (o_conf[1] !== 1'b1) begin n_fail++; $display("FAIL conf_pulse_c1: got %b exp 1", o_conf[1]); end
    n_cmp++; if (ccnt != 1)  begin n_fail++; $display("FAIL conf_count: got %0d exp 1", ccnt); end
    n_cmp++; if (wcnt != 16) begin n_fail++; $display("FAIL conf_wack_count: got %0d exp 16", wcnt); end
    n_cmp++; if (rcnt != 0)  begin n_fail++; $display("FAIL conf_rvalid_count: got %0d exp 0", rcnt); end
    n_cmp++; if (o_busy[22] !== 1'b0) begin n_fail++; $display("FAIL conf_idle_c22: got %b exp 0", o_busy[22]); end
    // mem_read still high: accepted at the very next edge.
    run_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 22);
    n_cmp++; if (o_busy[1] !== 1'b1 || o_conf[1] !== 1'b0) begin n_fail++; $display("FAIL conf_held_read_accept: got busy %b conf %b exp 1 0", o_busy[1], o_conf[1]); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (o_rdata[5+k] !== 32'h200 + 32'(k)) begin n_fail++; $display("FAIL conf_readback k%0d: got %h exp %h", k, o_rdata[5+k], 32'h200 + 32'(k)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    run_txn(1'b0, 1'b1, 32'h0000_00C0, 32'h300, 1'b0, 22);
    run_txn(1'b1, 1'b0, 32'h0000_00C0, 32'h0, 1'b0, 12);
    n_cmp++; if (o_rdata[12] !== 32'h307 || o_beat[12] !== 4'd7) begin n_fail++; $display("FAIL rmid_beat7: got %h/%0d exp 00000307/7", o_rdata[12], o_beat[12]); end
    rst_b = 1'b0;
    #1;
    n_cmp++; if (if0.mem_read_data !== 32'h0 || if0.mem_rvalid !== 1'b0 || if0.mem_beat !== 4'h0) begin
      n_fail++; $display("FAIL rmid_async_data: got %h %b %0d exp 0 0 0", if0.mem_read_data, if0.mem_rvalid, if0.mem_beat); end
    n_cmp++; if (if0.mem_busy !== 1'b0 || if0.mem_done !== 1'b0 || if0.mem_wack !== 1'b0 || if0.mem_conflict !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async_ctrl: got %b%b%b%b exp 0000", if0.mem_busy, if0.mem_done, if0.mem_wack, if0.mem_conflict); end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (if0.mem_done !== 1'b0 || if0.mem_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done c%0d: got done %b busy %b exp 0 0", c, if0.mem_done, if0.mem_busy); end
    end
    run_txn(1'b1, 1'b0, 32'h0000_00C0, 32'h0, 1'b0, 22);
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (o_rdata[5+k] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rmid_cleared k%0d: got %h exp deadbeef", k, o_rdata[5+k]); end
    end
  endtask

  task automatic test_latency1();
    int dcnt, wcnt;
    if1.mem_read = 1'b1; if1.mem_addr = 32'h0000_0040;
    @(posedge clk);
    #1 if1.mem_read = 1'b0;
    @(negedge clk);
    n_cmp++; if (if1.mem_busy !== 1'b1 || if1.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat1_wait: got busy %b rvalid %b exp 1 0", if1.mem_busy, if1.mem_rvalid); end
    // A new request during WAIT must be ignored.
    if1.mem_write = 1'b1; if1.mem_read = 1'b1;
    @(posedge clk);
    #1 begin if1.mem_write = 1'b0; if1.mem_read = 1'b0; end
    dcnt = 0; wcnt = 0;
    for (int c = 2; c <= 26; c++) begin
      @(negedge clk);
      if (if1.mem_done === 1'b1) dcnt++;
      if (if1.mem_wack === 1'b1) wcnt++;
      if (c == 2) begin
        n_cmp++; if (if1.mem_rvalid !== 1'b1 || if1.mem_beat !== 4'd0 || if1.mem_read_data !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL lat1_beat0_c2: got %b/%0d/%h exp 1/0/deadbeef", if1.mem_rvalid, if1.mem_beat, if1.mem_read_data); end
      end
      if (c == 17) begin
        n_cmp++; if (if1.mem_rvalid !== 1'b1 || if1.mem_beat !== 4'd15) begin n_fail++; $display("FAIL lat1_beat15_c17: got %b/%0d exp 1/15", if1.mem_rvalid, if1.mem_beat); end
      end
      if (c == 18) begin
        n_cmp++; if (if1.mem_done !== 1'b1) begin n_fail++; $display("FAIL lat1_done_c18: got %b exp 1", if1.mem_done); end
      end
      if (c >= 19) begin
        n_cmp++; if (if1.mem_busy !== 1'b0) begin n_fail++; $display("FAIL lat1_no_extra c%0d: got busy %b exp 0", c, if1.mem_busy); end
      end
    end
    n_cmp++; if (dcnt != 1) begin n_fail++; $display("FAIL lat1_done_count: got %0d exp 1", dcnt); end
    n_cmp++; if (wcnt != 0) begin n_fail++; $display("FAIL lat1_wack_count: got %0d exp 0", wcnt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_read_init();
    test_write_read();
    test_wrap();
    test_conflict();
    test_reset_mid_burst();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Backing-memory responder for the 4-way set-associative cache controller: it answers the controller's line-granular `mem_read` (refill) and `mem_write` (write-back) requests. It sits on the memory side of the cache's `mem_*` interface. It models a fixed access latency followed by a 16-beat burst of one 64-byte line, and holds a word-addressed storage array. It is used as the memory model in cache benches and as the template for the real memory-port adapter.

## Interface
- `DATA_W`, 32: word width.
- `DEPTH_WORDS`, 1024: storage depth in words. Must be a power of two and a multiple of 16.
- `LATENCY`, 4: cycles spent in WAIT before the first beat. Valid range 1..255.
- `INIT_WORD`, 32'hDEADBEEF: value returned for any word not written since reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  line-refill request; level, sampled only in IDLE.
- `mem_write`  in  1  line write-back request; level, sampled only in IDLE.
- `mem_addr`  in  32  byte address. Bits [5:0] are ignored; bits [31:6] give the line.
- `mem_write_data`  in  DATA_W  write-back word for the current beat.
- `mem_read_data`  out  DATA_W  refill word for the current beat. Registered.
- `mem_rvalid`  out  1  `mem_read_data` holds beat `mem_beat` of a refill.
- `mem_wack`  out  1  `mem_write_data` is captured at the end of this cycle.
- `mem_beat`  out  4  current beat index, 0..15.
- `mem_busy`  out  1  high in every state except IDLE.
- `mem_done`  out  1  one-cycle pulse: transaction complete.
- `mem_conflict`  out  1  one-cycle pulse: `mem_read` and `mem_write` were both high when sampled in IDLE.

## Operation
- States: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE, at an edge:
  - `mem_write`=1: latch line = `mem_addr[31:6]`, set op=write, go to WAIT, load the latency counter with LATENCY-1.
  - `mem_write`=0 and `mem_read`=1: same, with op=read.
  - Write has priority. If both are high, pulse `mem_conflict` in the next cycle; the read is not queued.
- WAIT:
  - Decrement the counter at each edge.
  - At the edge where the counter is 0, go to RBURST (op=read) or WBURST (op=write), with beat=0.
- Word index = ({line, beat}) mod DEPTH_WORDS. Addresses alias with wrap-around and no error.
- RBURST:
  - Each cycle shows `mem_rvalid`=1, `mem_beat`=beat and `mem_read_data`=storage[index]. Any word whose written bit is clear returns INIT_WORD.
  - The data register is loaded at the edge entering each beat.
  - Beat increments each edge. After beat 15, go to DONE.
- WBURST:
  - Each cycle shows `mem_wack`=1 and `mem_beat`=beat.
  - At the edge, store `mem_write_data` into storage[index] and set its written bit.
  - After beat 15, go to DONE.
- DONE: `mem_done`=1 for one cycle, then go to IDLE.
- `mem_read` and `mem_write` are ignored in WAIT, RBURST, WBURST and DONE.
- A request still high in IDLE starts a new transaction, so the requester drops its request on `mem_done`.
- Written bits: one per word, cleared by reset. The storage array itself is not reset.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.

## Timing
- Reset (`rst_b`=0, takes effect immediately): state=IDLE, and all of the following are 0:
  - `mem_read_data`, `mem_rvalid`, `mem_wack`, `mem_beat`, `mem_busy`, `mem_done`, `mem_conflict`, and every written bit.
- Reset mid-burst: the burst is abandoned with no `mem_done`. After release, every word reads as INIT_WORD.
- Cycle numbering: request sampled at edge E0.
  - `mem_busy` rises in cycle 1.
  - WAIT occupies cycles 1..LATENCY.
  - Beat k occupies cycle LATENCY+1+k.
  - `mem_done` is high in cycle LATENCY+17.
  - IDLE resumes in cycle LATENCY+18.
- Transaction length: LATENCY+17 busy cycles. Minimum spacing between accepts: LATENCY+18 cycles.
- Beats are back-to-back with no stalls. The requester must present write word k in the cycle where `mem_beat`=k.

## Test plan
- Reset, then read 0x0000_0040 (LATENCY=4): `mem_busy` rises 1 cycle after accept. 16 beats of 0xDEADBEEF appear in cycles 5..20 with `mem_beat` 0..15. `mem_done` pulses in cycle 21.
- Write 0x0000_0040 with word k = 0x100+k, then read 0x0000_0040: `mem_wack` is high for 16 cycles; the read returns 0x100..0x10F in order; exactly one `mem_done` pulse per transaction.
- Wrap-around (DEPTH_WORDS=1024): write 0x0000_1040 with 0xA0+k, then read 0x0000_0040: the read returns 0xA0..0xAF.
- Both requests high in IDLE: `mem_conflict` pulses once, a write burst runs, and storage reflects the write. With `mem_read` held through the burst, it is accepted only after returning to IDLE.
- Reset asserted during RBURST beat 7: all outputs are 0 immediately and no `mem_done` occurs. A later read of a previously written line returns 0xDEADBEEF.
- LATENCY=1: beat 0 appears in cycle 2 after accept. A new request arriving during WAIT is ignored and produces no extra transaction.
